// File: rtl/dff_pipe_en.sv
// dff_pipe_en: WIDTH x DEPTH elastic register pipeline with per-stage
// valid bits, global enable, bubble collapse, flush and occupancy count.
// Ports:
//   clk, reset      rising-edge clock, async active-high reset
//   e, flush        global enable (0 freezes), sync clear of valids
//   d, d_valid      producer data / valid
//   d_ready         pipeline accepts d this cycle
//   q, q_valid      output stage data / valid
//   q_ready         consumer accepts q this cycle
//   count           number of valid stages
module dff_pipe_en #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       e,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_valid,
  output logic                       d_ready,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  input  logic                       q_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] in_v;
  logic [WIDTH-1:0] data [DEPTH];
  logic [WIDTH-1:0] in_d [DEPTH];
  logic             en;
  logic             go_k;
  logic             up;
  logic             in_x;
  logic             out_x;

  // Reset also blocks the handshake so nothing is offered while held.
  assign en = e & ~flush & ~reset;

  // Ready ripples from the consumer back to stage 0; an empty stage
  // always loads, which is what closes bubbles during a stall.
  always_comb begin
    load = '0;
    go_k = 1'b0;
    up   = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (k == DEPTH - 1)
        go_k = v[k] & q_ready;
      else
        go_k = v[k] & up;
      up      = en & (~v[k] | go_k);
      load[k] = up;
    end
  end

  always_comb begin
    in_v    = '0;
    in_v[0] = d_valid;
    for (int k = 0; k < DEPTH; k++)
      in_d[k] = d;
    for (int k = 1; k < DEPTH; k++) begin
      in_v[k] = v[k-1];
      in_d[k] = data[k-1];
    end
  end

  assign d_ready = load[0];
  assign q_valid = v[DEPTH-1] & en;
  assign q       = data[DEPTH-1];
  assign in_x    = d_valid & d_ready;
  assign out_x   = q_valid & q_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v     <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++)
        data[k] <= RESET_VAL;
    end else if (e) begin
      if (flush) begin
        // Only valids are cleared; data registers keep their contents.
        v     <= '0;
        count <= '0;
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (load[k]) begin
            v[k] <= in_v[k];
            if (in_v[k])
              data[k] <= in_d[k];
          end
        end
        count <= count + CW'(in_x) - CW'(out_x);
      end
    end
  end

endmodule

// File: tb/tb_dff_pipe_en.sv
// tb_dff_pipe_en: directed table-driven bench for dff_pipe_en,
// DEPTH=4 main instance plus a DEPTH=1 instance.
module tb_dff_pipe_en;

  typedef struct {
    logic       e;
    logic       fl;
    logic [7:0] d;
    logic       dv;
    logic       qr;
    logic       xdr;
    logic       xqv;
    logic [7:0] xq;
    logic [2:0] xc;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       e, flush, d_valid, q_ready;
  logic [7:0] d;
  logic       d_ready, q_valid;
  logic [7:0] q;
  logic [2:0] count;

  logic       d1_valid, q1_ready;
  logic [7:0] d1;
  logic       d1_ready, q1_valid;
  logic [7:0] q1;
  logic [0:0] count1;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[$];

  dff_pipe_en #(.WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .e(e), .flush(flush),
    .d(d), .d_valid(d_valid), .d_ready(d_ready),
    .q(q), .q_valid(q_valid), .q_ready(q_ready),
    .count(count)
  );

  dff_pipe_en #(.WIDTH(8), .DEPTH(1)) u1 (
    .clk(clk), .reset(reset), .e(1'b1), .flush(1'b0),
    .d(d1), .d_valid(d1_valid), .d_ready(d1_ready),
    .q(q1), .q_valid(q1_valid), .q_ready(q1_ready),
    .count(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic ee, input logic ff,
                     input logic [7:0] dd, input logic dvv,
                     input logic qrr, input logic xdr,
                     input logic xqv, input logic [7:0] xq,
                     input logic [2:0] xc);
    vec_t t;
    t.e = ee; t.fl = ff; t.d = dd; t.dv = dvv; t.qr = qrr;
    t.xdr = xdr; t.xqv = xqv; t.xq = xq; t.xc = xc;
    tbl.push_back(t);
  endtask

  task automatic chk4(input string nm, input logic xdr,
                      input logic xqv, input logic [7:0] xq,
                      input logic [2:0] xc);
    chk({nm, " d_ready"}, 32'(d_ready), 32'(xdr));
    chk({nm, " q_valid"}, 32'(q_valid), 32'(xqv));
    chk({nm, " q"}, 32'(q), 32'(xq));
    chk({nm, " count"}, 32'(count), 32'(xc));
  endtask

  task automatic chk1(input string nm, input logic xdr,
                      input logic xqv, input logic [7:0] xq,
                      input logic xc, input logic cq);
    chk({nm, " d_ready"}, 32'(d1_ready), 32'(xdr));
    chk({nm, " q_valid"}, 32'(q1_valid), 32'(xqv));
    if (cq) chk({nm, " q"}, 32'(q1), 32'(xq));
    chk({nm, " count"}, 32'(count1), 32'(xc));
  endtask

  initial begin
    // fill, q_ready=1
    add(1,0,8'h11,1,1, 1,0,8'h00,0);
    add(1,0,8'h22,1,1, 1,0,8'h00,1);
    add(1,0,8'h33,1,1, 1,0,8'h00,2);
    add(1,0,8'h00,0,1, 1,0,8'h00,3);
    add(1,0,8'h00,0,1, 1,1,8'h11,3);
    add(1,0,8'h00,0,1, 1,1,8'h22,2);
    add(1,0,8'h00,0,1, 1,1,8'h33,1);
    add(1,0,8'h00,0,1, 1,0,8'h33,0);
    // backpressure / full
    add(1,0,8'hA0,1,0, 1,0,8'h33,0);
    add(1,0,8'hA1,1,0, 1,0,8'h33,1);
    add(1,0,8'hA2,1,0, 1,0,8'h33,2);
    add(1,0,8'hA3,1,0, 1,0,8'h33,3);
    add(1,0,8'hA4,1,0, 0,1,8'hA0,4);
    add(1,0,8'hA4,1,0, 0,1,8'hA0,4);
    add(1,0,8'hA4,1,1, 1,1,8'hA0,4);
    add(1,0,8'hA5,1,1, 1,1,8'hA1,4);
    add(1,0,8'h00,0,1, 1,1,8'hA2,4);
    add(1,0,8'h00,0,1, 1,1,8'hA3,3);
    add(1,0,8'h00,0,1, 1,1,8'hA4,2);
    add(1,0,8'h00,0,1, 1,1,8'hA5,1);
    add(1,0,8'h00,0,1, 1,0,8'hA5,0);
    // bubble collapse
    add(1,0,8'h55,1,0, 1,0,8'hA5,0);
    add(1,0,8'h00,0,0, 1,0,8'hA5,1);
    add(1,0,8'h00,0,0, 1,0,8'hA5,1);
    add(1,0,8'h66,1,0, 1,0,8'hA5,1);
    add(1,0,8'h00,0,0, 1,1,8'h55,2);
    add(1,0,8'h00,0,0, 1,1,8'h55,2);
    add(1,0,8'h00,0,0, 1,1,8'h55,2);
    add(1,0,8'h00,0,1, 1,1,8'h55,2);
    add(1,0,8'h00,0,1, 1,1,8'h66,1);
    add(1,0,8'h00,0,1, 1,0,8'h66,0);
    // enable stall
    add(1,0,8'hB1,1,1, 1,0,8'h66,0);
    add(1,0,8'hB2,1,1, 1,0,8'h66,1);
    add(1,0,8'hB3,1,1, 1,0,8'h66,2);
    for (int i = 0; i < 5; i++)
      add(0,0,8'hC0,1,1, 0,0,8'h66,3);
    add(1,0,8'h00,0,1, 1,0,8'h66,3);
    add(0,0,8'h00,0,1, 0,0,8'hB1,3);
    add(1,0,8'h00,0,1, 1,1,8'hB1,3);
    add(1,0,8'h00,0,1, 1,1,8'hB2,2);
    add(1,0,8'h00,0,1, 1,1,8'hB3,1);
    add(1,0,8'h00,0,1, 1,0,8'hB3,0);
    // flush
    add(1,0,8'hC1,1,0, 1,0,8'hB3,0);
    add(1,0,8'hC2,1,0, 1,0,8'hB3,1);
    add(1,0,8'hC3,1,0, 1,0,8'hB3,2);
    add(1,1,8'h77,1,1, 0,0,8'hB3,3);
    add(1,0,8'h00,0,1, 1,0,8'hB3,0);
    add(1,0,8'h88,1,1, 1,0,8'hB3,0);
    add(1,0,8'h00,0,1, 1,0,8'hB3,1);
    add(1,0,8'h00,0,1, 1,0,8'hB3,1);
    add(1,0,8'h00,0,1, 1,0,8'hB3,1);
    add(1,0,8'h00,0,1, 1,1,8'h88,1);
    add(1,0,8'h00,0,1, 1,0,8'h88,0);

    reset = 1'b0;
    e = 1'b1; flush = 1'b0; d = '0; d_valid = 1'b0; q_ready = 1'b1;
    d1 = '0; d1_valid = 1'b0; q1_ready = 1'b1;

    // async reset asserted mid-cycle
    #2 reset = 1'b1;
    #1;
    chk4("rst0", 0, 0, 8'h00, 0);
    chk1("rst0 d1", 0, 0, 8'h00, 0, 1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      e = tbl[i].e; flush = tbl[i].fl; d = tbl[i].d;
      d_valid = tbl[i].dv; q_ready = tbl[i].qr;
      #1;
      chk4($sformatf("vec%0d", i), tbl[i].xdr, tbl[i].xqv,
           tbl[i].xq, tbl[i].xc);
    end

    // reset in mid-operation discards contents
    @(negedge clk);
    e = 1'b1; flush = 1'b0; d = 8'hE1; d_valid = 1'b1;
    q_ready = 1'b0;
    #1;
    chk4("pre-rst", 1, 0, 8'h88, 0);
    @(negedge clk);
    d_valid = 1'b0; q_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk4("rst1", 0, 0, 8'h00, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk4($sformatf("post-rst%0d", i), 1, 0, 8'h00, 0);
    end

    // DEPTH=1: q follows d one cycle later, count stays 1
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      d1 = 8'(i); d1_valid = 1'b1; q1_ready = 1'b1;
      #1;
      chk1($sformatf("d1 s%0d", i), 1, i != 0, 8'(i - 1),
           i != 0, i != 0);
    end
    @(negedge clk);
    d1 = 8'hAA; d1_valid = 1'b1; q1_ready = 1'b0;
    #1;
    chk1("d1 full", 0, 1, 8'h09, 1, 1);
    @(negedge clk);
    d1_valid = 1'b0; q1_ready = 1'b1;
    #1;
    chk1("d1 drain", 1, 1, 8'h09, 1, 1);
    @(negedge clk);
    #1;
    chk1("d1 empty", 1, 0, 8'h09, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dff_pipe_en.md
Name: dff_pipe_en

Overview:
- Parametrised successor to the single-bit enabled flip-flop.
- A WIDTH-bit, DEPTH-stage elastic register pipeline with per-stage valid bits, a global enable (stall), bubble collapse, synchronous flush and an occupancy count.
- Sits between producer and consumer datapath blocks as a retiming/buffering stage with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, data bits per stage.
- DEPTH, 4, number of register stages; legal range is 1 or more.
- RESET_VAL, 0, value loaded into every stage data register on reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- e  in  1  global enable; 0 freezes all state
- flush  in  1  synchronous clear of all valid bits
- d  in  WIDTH  input data
- d_valid  in  1  input data valid
- d_ready  out  1  pipeline accepts d this cycle
- q  out  WIDTH  output data (data register of stage DEPTH-1)
- q_valid  out  1  output data valid
- q_ready  in  1  consumer accepts q this cycle
- count  out  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Reset (async, asserted): all v[k]=0, all data[k]=RESET_VAL, count=0. Outputs are therefore q=RESET_VAL, q_valid=0, d_ready=0 while reset is high. Reset released mid-operation discards all contents.
- Stage 0 is the input stage; stage DEPTH-1 is the output stage.
- go[DEPTH-1] = v[DEPTH-1] & q_ready.
- go[k] = v[k] & load[k+1], for k < DEPTH-1.
- load[k] = e & ~flush & (~v[k] | go[k]).
- Combinational outputs:
  - d_ready = load[0].
  - q_valid = v[DEPTH-1] & e & ~flush.
  - q = data[DEPTH-1].
- Input transfer: d_valid & d_ready. Output transfer: q_valid & q_ready.
- On a clock edge with load[k]=1:
  - v[k] takes in_v, where in_v is d_valid for k=0, else v[k-1].
  - data[k] takes in_d only if in_v=1; otherwise data[k] holds.
- On a clock edge with load[k]=0, stage k holds.
- Bubble collapse: an empty stage always loads from its predecessor, so gaps close while the output stalls.
- e=0: no state changes at all; d_ready=0; q_valid=0; count holds.
- flush=1 (requires e irrespective): on the next edge all v[k]=0 and count=0; data registers hold. Flush has priority over any load. No transfer occurs in a flush cycle because d_ready=0 and q_valid=0.
- Latency: an item accepted at edge t into an empty pipe, with e=1, is presented with q_valid=1 in the cycle after edge t+DEPTH-1. That is DEPTH cycles of latency.
- Throughput: one item per cycle when q_ready=1 and e=1.
- Full (count==DEPTH):
  - q_ready=0 gives d_ready=0.
  - q_ready=1 gives d_ready=1 in the same cycle, so accept and emit occur together and count is unchanged.
- Empty (count==0): q_valid=0; d_ready=e&~flush.
- count update: count_next = count + in_xfer − out_xfer, saturating-free because the handshake guarantees 0..DEPTH. On flush, count_next=0.
- The ready path from q_ready to d_ready is combinational through all stages. This is intentional; no registered-ready mode is provided.
- DEPTH=1 degenerates to one enabled register with a valid bit and the same rules.

Test Plan:
- Reset, then fill: WIDTH=8, DEPTH=4, reset pulse mid-cycle, e=1, q_ready=1, push 0x11,0x22,0x33 on consecutive cycles. Expect q_valid asserted 4 cycles after the first accept, q=0x11,0x22,0x33 back-to-back, count peaks at 3. During reset, q=0x00, q_valid=0 asynchronously.
- Backpressure/full: q_ready=0, push 0xA0..0xA5. Expect 4 accepted and d_ready=0 thereafter, count=4. Raise q_ready, then expect 0xA0,0xA1,0xA2,0xA3 in order, and 0xA4 accepted in the same cycle 0xA0 leaves.
- Bubble collapse: q_ready=0, push 0x55, idle 2 cycles, push 0x66. Expect count=2 and stages 3 and 2 valid after settling. With q_ready=1, 0x55 then 0x66 are output on consecutive cycles.
- Enable stall: while 3 items are in flight, drop e for 5 cycles. Expect all v, data and count frozen, d_ready=0, q_valid=0. With e=1 again, the stream resumes with no loss or duplication.
- Flush: count=3, assert flush for 1 cycle with d_valid=1, d=0x77. Expect next cycle count=0, q_valid=0, 0x77 not accepted. A subsequent push of 0x88 emerges alone after 4 cycles.
- Simultaneous accept/emit at full, DEPTH=1 build: q_ready=1, d_valid=1 every cycle, d=0..9. Expect q to follow d one cycle later, count constant at 1.
